// File: rtl/mdu_arbiter_if.sv
// Bundle of the two requester ports and the MDU control/data port served by mdu_arbiter.
// The arbiter uses the slave view; requesters and the MDU sit on the master view.
interface mdu_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_type;
  logic [DATA_W-1:0] req0_rs;
  logic [DATA_W-1:0] req0_rt;
  logic              resp0_valid;
  logic              resp0_ready;
  logic [DATA_W-1:0] resp0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_type;
  logic [DATA_W-1:0] req1_rs;
  logic [DATA_W-1:0] req1_rt;
  logic              resp1_valid;
  logic              resp1_ready;
  logic [DATA_W-1:0] resp1_data;

  logic              mdu_start;
  logic [3:0]        mdu_type;
  logic [DATA_W-1:0] mdu_rs;
  logic [DATA_W-1:0] mdu_rt;
  logic              mdu_busy;
  logic [DATA_W-1:0] mdu_out;

  modport slave (
    input  req0_valid, req0_type, req0_rs, req0_rt, resp0_ready,
    input  req1_valid, req1_type, req1_rs, req1_rt, resp1_ready,
    input  mdu_busy, mdu_out,
    output req0_ready, resp0_valid, resp0_data,
    output req1_ready, resp1_valid, resp1_data,
    output mdu_start, mdu_type, mdu_rs, mdu_rt
  );

  modport master (
    output req0_valid, req0_type, req0_rs, req0_rt, resp0_ready,
    output req1_valid, req1_type, req1_rs, req1_rt, resp1_ready,
    output mdu_busy, mdu_out,
    input  req0_ready, resp0_valid, resp0_data,
    input  req1_ready, resp1_valid, resp1_data,
    input  mdu_start, mdu_type, mdu_rs, mdu_rt
  );
endinterface

// File: rtl/mdu_arbiter.sv
// Two-requester arbiter in front of a single multiply/divide unit. One operation is in flight
// at a time: IDLE grants, ISSUE drives the MDU, BUSY waits for mult/div, RESP holds the result.
// Optional feature: define MDU_ARB_RR_EN for round-robin on simultaneous requests; otherwise
// requester 0 always wins.
module mdu_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input logic          clk,
  input logic          reset,
  mdu_arbiter_if.slave bus
);

  // MDU operation codes; must match the core's MDU_* encodings.
  localparam logic [3:0] MduMult  = 4'd1;
  localparam logic [3:0] MduMultu = 4'd2;
  localparam logic [3:0] MduDiv   = 4'd3;
  localparam logic [3:0] MduDivu  = 4'd4;
  localparam logic [3:0] MduMfhi  = 4'd5;
  localparam logic [3:0] MduMflo  = 4'd6;
  localparam logic [3:0] MduMthi  = 4'd7;
  localparam logic [3:0] MduMtlo  = 4'd8;

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [3:0]        type_q, type_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic grant0, grant1, pick1, start;
  logic op_long, op_start, op_mf;

  assign op_long  = type_q inside {MduMult, MduMultu, MduDiv, MduDivu};
  assign op_start = op_long || (type_q inside {MduMthi, MduMtlo});
  assign op_mf    = type_q inside {MduMfhi, MduMflo};

`ifdef MDU_ARB_RR_EN
  logic last_q, last_d;

  // On a tie, requester 1 wins only if requester 0 was granted last.
  assign pick1  = bus.req1_valid && (!bus.req0_valid || !last_q);
  assign last_d = grant1 ? 1'b1 : (grant0 ? 1'b0 : last_q);

  // Last-grant pointer; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  assign pick1 = bus.req1_valid && !bus.req0_valid;
`endif

  // Next-state, capture and grant logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    type_d      = type_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    resp_data_d = resp_data_q;
    grant0      = 1'b0;
    grant1      = 1'b0;
    start       = 1'b0;
    case (state_q)
      StIdle: begin
        // Grants are withheld while the MDU is busy and during the reset cycle.
        if (!reset && !bus.mdu_busy && (bus.req0_valid || bus.req1_valid)) begin
          grant0  = !pick1;
          grant1  = pick1;
          owner_d = pick1;
          type_d  = pick1 ? bus.req1_type : bus.req0_type;
          rs_d    = pick1 ? bus.req1_rs : bus.req0_rs;
          rt_d    = pick1 ? bus.req1_rt : bus.req0_rt;
          state_d = StIssue;
        end
      end
      StIssue: begin
        start       = op_start;
        // MF* results are read combinationally from the MDU this cycle; everything else
        // answers with zero.
        resp_data_d = op_mf ? bus.mdu_out : '0;
        state_d     = op_long ? StBusy : StResp;
      end
      StBusy: begin
        if (!bus.mdu_busy) state_d = StResp;
      end
      StResp: begin
        if (owner_q ? bus.resp1_ready : bus.resp0_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      type_q      <= 4'd0;
      rs_q        <= '0;
      rt_q        <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      type_q      <= type_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.resp0_valid = (state_q == StResp) && !owner_q;
  assign bus.resp1_valid = (state_q == StResp) && owner_q;
  assign bus.resp0_data  = bus.resp0_valid ? resp_data_q : '0;
  assign bus.resp1_data  = bus.resp1_valid ? resp_data_q : '0;
  assign bus.mdu_start   = start;
  assign bus.mdu_type    = (state_q == StIssue) ? type_q : 4'd0;
  assign bus.mdu_rs      = rs_q;
  assign bus.mdu_rt      = rt_q;

endmodule

// File: tb/tb_mdu_arbiter.sv
// Testbench for mdu_arbiter: table of single operations plus directed sequences for
// busy masking, response hold, reset mid-divide and simultaneous-request arbitration.
// Honours MDU_ARB_RR_EN for the arbitration expectations.
module tb_mdu_arbiter;

  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MFHI  = 4'd5;
  localparam logic [3:0] MFLO  = 4'd6;
  localparam logic [3:0] MTHI  = 4'd7;
  localparam logic [3:0] MTLO  = 4'd8;

  typedef struct packed {
    logic        sel;
    logic [3:0]  typ;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        start;  // expected mdu_start in ISSUE
    logic [3:0]  lat;    // expected accept-to-response cycles, 0 = not checked
    logic [31:0] data;   // expected response data
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic force_busy = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mdu_arbiter_if bus ();

  mdu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural MDU: MULT* busy 5 cycles, DIV* busy 10 cycles, results land at start.
  logic [31:0] hi, lo;
  logic        model_busy;
  int          cnt;
  logic [63:0] prod_s, prod_u;
  logic [31:0] q_s, r_s, q_u, r_u;

  assign prod_s = {{32{bus.mdu_rs[31]}}, bus.mdu_rs} * {{32{bus.mdu_rt[31]}}, bus.mdu_rt};
  assign prod_u = {32'd0, bus.mdu_rs} * {32'd0, bus.mdu_rt};

  always_comb begin
    q_s = '0; r_s = '0; q_u = '0; r_u = '0;
    if (bus.mdu_rt != 32'd0) begin
      q_s = $signed(bus.mdu_rs) / $signed(bus.mdu_rt);
      r_s = $signed(bus.mdu_rs) % $signed(bus.mdu_rt);
      q_u = bus.mdu_rs / bus.mdu_rt;
      r_u = bus.mdu_rs % bus.mdu_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0; lo <= '0; model_busy <= 1'b0; cnt <= 0;
    end else if (bus.mdu_start) begin
      case (bus.mdu_type)
        MULT:  begin {hi, lo} <= prod_s; model_busy <= 1'b1; cnt <= 5; end
        MULTU: begin {hi, lo} <= prod_u; model_busy <= 1'b1; cnt <= 5; end
        DIV:   begin
          if (bus.mdu_rt != 32'd0) begin lo <= q_s; hi <= r_s; end
          model_busy <= 1'b1; cnt <= 10;
        end
        DIVU:  begin
          if (bus.mdu_rt != 32'd0) begin lo <= q_u; hi <= r_u; end
          model_busy <= 1'b1; cnt <= 10;
        end
        MTHI:  hi <= bus.mdu_rs;
        MTLO:  lo <= bus.mdu_rs;
        default: ;
      endcase
    end else if (model_busy) begin
      if (cnt == 1) model_busy <= 1'b0;
      cnt <= cnt - 1;
    end
  end

  assign bus.mdu_busy = model_busy | force_busy;
  assign bus.mdu_out  = (bus.mdu_type == MFHI) ? hi : ((bus.mdu_type == MFLO) ? lo : 32'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input logic s);
    return s ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rv(input logic s);
    return s ? bus.resp1_valid : bus.resp0_valid;
  endfunction

  function automatic logic [31:0] rd(input logic s);
    return s ? bus.resp1_data : bus.resp0_data;
  endfunction

  task automatic set_req(input logic s, input logic v, input logic [3:0] t,
                         input logic [31:0] a, input logic [31:0] b);
    if (s) begin
      bus.req1_valid = v; bus.req1_type = t; bus.req1_rs = a; bus.req1_rt = b;
    end else begin
      bus.req0_valid = v; bus.req0_type = t; bus.req0_rs = a; bus.req0_rt = b;
    end
  endtask

  task automatic set_rr(input logic s, input logic v);
    if (s) bus.resp1_ready = v;
    else   bus.resp0_ready = v;
  endtask

  // Complete one operation from a single requester; the other requester keeps a request
  // pending while the operation is in flight to prove it is never granted.
  task automatic do_op(input vec_t v, input string nm);
    int n;
    int cyc;
    logic ok;
    @(negedge clk);
    set_req(!v.sel, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(v.sel, 1'b1, v.typ, v.rs, v.rt);
    #1;
    n = 0;
    while (!rdy(v.sel) && n < 50) begin @(negedge clk); #1; n++; end
    chk({nm, "_grant"}, 32'(rdy(v.sel)), 32'd1);
    chk({nm, "_nogrant"}, 32'(rdy(!v.sel)), 32'd0);
    @(negedge clk);  // ISSUE
    set_req(v.sel, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(!v.sel, 1'b1, 4'hF, 32'd0, 32'd0);
    #1;
    chk({nm, "_start"}, 32'(bus.mdu_start), 32'(v.start));
    chk({nm, "_type"}, 32'(bus.mdu_type), 32'(v.typ));
    chk({nm, "_rs"}, bus.mdu_rs, v.rs);
    chk({nm, "_rt"}, bus.mdu_rt, v.rt);
    cyc = 1;
    ok = 1'b1;
    while (!rv(v.sel) && cyc < 200) begin
      @(negedge clk); #1; cyc++;
      if (bus.req0_ready || bus.req1_ready) ok = 1'b0;
    end
    chk({nm, "_noready"}, 32'(ok), 32'd1);
    chk({nm, "_respv"}, 32'(rv(v.sel)), 32'd1);
    if (v.lat != 4'd0) chk({nm, "_lat"}, 32'(cyc), 32'(v.lat));
    chk({nm, "_data"}, rd(v.sel), v.data);
    chk({nm, "_otherv"}, 32'(rv(!v.sel)), 32'd0);
    chk({nm, "_idle_mdu"}, {27'd0, bus.mdu_start, bus.mdu_type}, 32'd0);
    set_rr(v.sel, 1'b1);
    set_req(!v.sel, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    set_rr(v.sel, 1'b0);
    #1;
    chk({nm, "_done"}, 32'(rv(v.sel)), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t        vecs [17];
  vec_t        v;
  logic [31:0] held;
  logic [3:0]  exp_pat;
  logic        who;
  int          n;

  initial begin
    vecs[0]  = '{1'b0, MULT,  32'd3,          32'hFFFFFFFE, 1'b1, 4'd0, 32'd0};
    vecs[1]  = '{1'b0, MFLO,  32'd0,          32'd0,        1'b0, 4'd2, 32'hFFFFFFFA};
    vecs[2]  = '{1'b0, MFHI,  32'd0,          32'd0,        1'b0, 4'd2, 32'hFFFFFFFF};
    vecs[3]  = '{1'b1, DIVU,  32'd100,        32'd7,        1'b1, 4'd0, 32'd0};
    vecs[4]  = '{1'b1, MFHI,  32'd0,          32'd0,        1'b0, 4'd2, 32'd2};
    vecs[5]  = '{1'b1, MFLO,  32'd0,          32'd0,        1'b0, 4'd2, 32'd14};
    vecs[6]  = '{1'b0, MTLO,  32'hDEADBEEF,   32'd0,        1'b1, 4'd2, 32'd0};
    vecs[7]  = '{1'b1, MFLO,  32'd0,          32'd0,        1'b0, 4'd2, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 4'hF,  32'd1,          32'd2,        1'b0, 4'd2, 32'd0};
    vecs[9]  = '{1'b1, MTHI,  32'h55,         32'd0,        1'b1, 4'd2, 32'd0};
    vecs[10] = '{1'b0, MFHI,  32'd0,          32'd0,        1'b0, 4'd2, 32'h55};
    vecs[11] = '{1'b0, DIV,   32'hFFFFFFEC,   32'd3,        1'b1, 4'd0, 32'd0};
    vecs[12] = '{1'b1, MFLO,  32'd0,          32'd0,        1'b0, 4'd2, 32'hFFFFFFFA};
    vecs[13] = '{1'b0, MFHI,  32'd0,          32'd0,        1'b0, 4'd2, 32'hFFFFFFFE};
    vecs[14] = '{1'b1, MULTU, 32'hFFFFFFFF,   32'd2,        1'b1, 4'd0, 32'd0};
    vecs[15] = '{1'b1, MFHI,  32'd0,          32'd0,        1'b0, 4'd2, 32'd1};
    vecs[16] = '{1'b0, 4'd0,  32'd9,          32'd9,        1'b0, 4'd2, 32'd0};

    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    set_req(1'b0, 1'b1, MTHI, 32'h11, 32'd0);
    set_req(1'b1, 1'b1, MTHI, 32'h22, 32'd0);

    // Reset: no grants while reset is high, then every output at its reset value.
    @(negedge clk); #1;
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk); #1;
    chk("rst_ready0_b", 32'(bus.req0_ready), 32'd0);
    chk("rst_respv", {30'd0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
    chk("rst_data", bus.resp0_data | bus.resp1_data, 32'd0);
    chk("rst_mdu", {27'd0, bus.mdu_start, bus.mdu_type}, 32'd0);
    chk("rst_rs_rt", bus.mdu_rs | bus.mdu_rt, 32'd0);
    set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Idle with MDU busy: requests are held off until busy drops.
    @(negedge clk);
    force_busy = 1'b1;
    set_req(1'b0, 1'b1, MTLO, 32'h1234, 32'd0);
    #1 chk("busymask_a", 32'(bus.req0_ready), 32'd0);
    @(negedge clk); #1;
    chk("busymask_b", 32'(bus.req0_ready), 32'd0);
    force_busy = 1'b0;
    #1 chk("busymask_release", 32'(bus.req0_ready), 32'd1);
    set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);

    // Response held for 5 cycles with a competing request pending.
    set_req(1'b0, 1'b1, MFLO, 32'd0, 32'd0);
    @(negedge clk);  // accepted at the previous edge window
    set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b1, MTHI, 32'h77, 32'd0);
    n = 0;
    #1;
    while (!bus.resp0_valid && n < 20) begin @(negedge clk); #1; n++; end
    held = 32'hFFFFFFFE;
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", 32'(bus.resp0_valid), 32'd1);
      chk("hold_data", bus.resp0_data, held);
      chk("hold_nogrant1", 32'(bus.req1_ready), 32'd0);
      @(negedge clk); #1;
    end
    bus.resp0_ready = 1'b1;
    #1 chk("resp_exit_nogrant", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.resp0_ready = 1'b0;
    #1 chk("idle_grant1", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    bus.resp1_ready = 1'b1;
    n = 0;
    #1;
    while (!bus.resp1_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk("hold_req1_resp", 32'(bus.resp1_valid), 32'd1);
    @(negedge clk);
    bus.resp1_ready = 1'b0;

    // Reset in the middle of a DIV.
    set_req(1'b0, 1'b1, DIV, 32'd100, 32'd7);
    #1 chk("rstdiv_grant", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);  // ISSUE
    set_req(1'b0, 1'b1, 4'hF, 32'd0, 32'd0);
    repeat (2) @(negedge clk);  // BUSY
    #1;
    chk("rstdiv_busy", 32'(bus.mdu_busy), 32'd1);
    chk("rstdiv_noready", 32'(bus.req0_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b1, MTHI, 32'd0, 32'd0);
    #1;
    chk("rstdiv_respv", {30'd0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
    chk("rstdiv_mdu", {27'd0, bus.mdu_start, bus.mdu_type}, 32'd0);
    chk("rstdiv_rs_rt", bus.mdu_rs | bus.mdu_rt, 32'd0);
    chk("rstdiv_idle", 32'(bus.req1_ready), 32'd1);
    set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    v = '{1'b0, MFLO, 32'd0, 32'd0, 1'b0, 4'd2, 32'd0};
    do_op(v, "rstdiv_mflo");

    // Simultaneous MTHI from both requesters, four grants.
    do_reset();
`ifdef MDU_ARB_RR_EN
    exp_pat = 4'b1010;
`else
    exp_pat = 4'b0000;
`endif
    set_req(1'b0, 1'b1, MTHI, 32'h11, 32'd0);
    set_req(1'b1, 1'b1, MTHI, 32'h22, 32'd0);
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      #1;
      while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin @(negedge clk); #1; n++; end
      chk($sformatf("rr_single%0d", g), 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      who = bus.req1_ready;
      chk($sformatf("rr_grant%0d", g), 32'(who), 32'(exp_pat[g]));
      chk($sformatf("rr_any%0d", g), 32'(bus.req0_ready | bus.req1_ready), 32'd1);
      @(negedge clk);  // ISSUE
      if (g == 3) begin
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
      end
      @(negedge clk); #1;  // RESP
      chk($sformatf("rr_resp%0d", g), 32'(rv(who)), 32'd1);
      @(negedge clk);
    end
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
`ifdef MDU_ARB_RR_EN
    v = '{1'b0, MFHI, 32'd0, 32'd0, 1'b0, 4'd2, 32'h22};
`else
    v = '{1'b0, MFHI, 32'd0, 32'd0, 1'b0, 4'd2, 32'h11};
`endif
    do_op(v, "rr_mfhi");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_arbiter.md
MDU_ARBITER -- requirements
Module: mdu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an MDU operation pending.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_type  input  4  MDU operation code, using the `MDU_* encodings from Constants.v.
REQ-007 reqN_rs, reqN_rt  input  32  operands.
REQ-008 respN_valid  output  1  completion/result available for requester N.
REQ-009 respN_ready  input  1  requester N consumes the response.
REQ-010 respN_data  output  32  MFHI/MFLO result; 0 for all other operations.
REQ-011 mdu_start, mdu_type[3:0], mdu_rs[31:0], mdu_rt[31:0]  output  drive the MDU start, MDType, RS and RT inputs.
REQ-012 mdu_busy  input  1, mdu_out  input  32  MDU busy and MDOut.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, BUSY and RESP.
REQ-014 IDLE: when any reqN_valid=1 and mdu_busy=0, the arbiter SHALL assert reqN_ready for exactly one requester (combinationally) and capture its type/rs/rt and owner ID; then go to ISSUE.
REQ-015 reqN_ready SHALL be 0 in every state except IDLE, and in IDLE while mdu_busy=1.
REQ-016 ISSUE (1 cycle): drive mdu_type and the captured operands. Assert mdu_start=1 for MTHI, MTLO, MULT, MULTU, DIV and DIVU.
REQ-017 ISSUE, MFHI/MFLO: mdu_start=0; capture mdu_out into the response register.
REQ-018 From ISSUE: MULT/MULTU/DIV/DIVU SHALL go to BUSY; all other codes go to RESP.
REQ-019 BUSY: the arbiter SHALL stay in BUSY while mdu_busy=1; on the first cycle mdu_busy=0 is sampled, go to RESP.
REQ-020 RESP: assert respN_valid for the owner only, with respN_data held stable; on respN_ready=1, return to IDLE.
REQ-021 An unrecognised type code SHALL complete via ISSUE->RESP with mdu_start=0 and respN_data=0.
REQ-022 Outside ISSUE, mdu_start=0 and mdu_type=4'd0; mdu_rs/mdu_rt hold their captured values.
REQ-023 Latency: acceptance in cycle T, then ISSUE in T+1, then respN_valid in T+2 for MT*/MF*.
REQ-024 At most one operation SHALL be in flight; a new request is not granted in the cycle RESP completes (earliest grant is the next IDLE cycle).
REQ-025 A requester's response SHALL NOT be dropped; RESP holds indefinitely while respN_ready=0.
REQ-026 Divide-by-zero SHALL be forwarded unchanged; the result is whatever the MDU produces.

Reset
REQ-027 On reset=1 at a clock edge, the state SHALL become IDLE in any state, including mid-BUSY; the MDU shares this reset.
REQ-028 Reset values: reqN_ready=0 during the reset cycle, respN_valid=0, respN_data=0, mdu_start=0, mdu_type=0, mdu_rs=0, mdu_rt=0, last-grant pointer=1.

Configuration
REQ-029 With MDU_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin to the requester not granted last; the pointer updates on each grant.
REQ-030 Without MDU_ARB_RR_EN, requester 0 SHALL always win simultaneous requests, and no pointer register exists.

Verification
REQ-031 req0 MULT rs=3, rt=0xFFFFFFFE; then req0 MFLO, then MFHI -> resp data 0xFFFFFFFA, then 0xFFFFFFFF.
REQ-032 req1 DIVU rs=100, rt=7; mdu_busy high -> arbiter stays in BUSY, reqN_ready=0 throughout; then MFHI -> 2, MFLO -> 14.
REQ-033 req0 and req1 both request MTHI (rs=0x11 and 0x22) in the same cycle, repeated 4 times -> with MDU_ARB_RR_EN, grants alternate 0,1,0,1; without it, all grants go to 0 while req0_valid stays high.
REQ-034 MFLO response held with resp0_ready=0 for 5 cycles -> resp0_valid and resp0_data stable; no grant issued to req1.
REQ-035 reset asserted during BUSY of a DIV -> next cycle is IDLE, all outputs at reset values; a following MFLO returns 0.
REQ-036 req0 MTLO rs=0xDEADBEEF accepted at T -> mdu_start=1 at T+1 only, resp0_valid at T+2; a subsequent MFLO returns 0xDEADBEEF.
